// File: rtl/traffic_light_monitor_if.sv
// ============================================================================
// Module      : traffic_light_monitor_if
// Description : Light buses observed by the monitor plus its fault/phase outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       n_light;
    logic [2:0]       e_light;
    logic [2:0]       s_light;
    logic [2:0]       w_light;
    logic             fault;
    logic [2:0]       fault_code;
    logic [1:0]       fault_dir;
    logic [CNT_W-1:0] fault_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic [1:0]       active_dir;

    modport master (
        output n_light, e_light, s_light, w_light,
        input  fault, fault_code, fault_dir, fault_cnt, phase_cnt, active_dir
    );

    modport slave (
        input  n_light, e_light, s_light, w_light,
        output fault, fault_code, fault_dir, fault_cnt, phase_cnt, active_dir
    );
endinterface

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive checker of a four-way controller's lights (N,E,S,W).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 16,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    traffic_light_monitor_if.slave bus
);
    localparam logic [2:0]       c_RED   = 3'b100;
    localparam logic [2:0]       c_YEL   = 3'b010;
    localparam logic [2:0]       c_GRN   = 3'b001;
    localparam logic [CNT_W-1:0] c_MIN_G = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] c_MAX_G = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] c_MIN_Y = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] c_MAX_Y = CNT_W'(MAX_YELLOW);

    logic [2:0]       w_cur  [4];
    logic [2:0]       r_prev [4];
    logic [CNT_W-1:0] r_dur  [4];
    logic             r_first_green;
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [1:0]       r_fault_dir;
    logic [CNT_W-1:0] r_fault_cnt;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [1:0]       r_active_dir;

    logic [3:0]       w_enc, w_gy, w_conf, w_trn, w_gsh, w_glg, w_yel, w_onset, w_ord;
    logic [7:0][3:0]  w_vec;
    logic [1:0]       w_succ;
    logic             w_any;
    logic [2:0]       w_code;
    logic [1:0]       w_dir;
    logic [2:0]       w_onset_num;

    function automatic logic [1:0] f_lowest(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (v[d]) idx = 2'(d);
        end
        return idx;
    endfunction

    assign w_cur  = '{bus.n_light, bus.e_light, bus.s_light, bus.w_light};
    assign w_succ = r_active_dir + 2'd1;

    always_comb begin
        w_enc   = '0;
        w_gy    = '0;
        w_trn   = '0;
        w_gsh   = '0;
        w_glg   = '0;
        w_yel   = '0;
        w_onset = '0;
        w_ord   = '0;
        for (int d = 0; d < 4; d++) begin
            w_enc[d]   = !$onehot(w_cur[d]);
            w_gy[d]    = w_cur[d][0] | w_cur[d][1];
            // Step legality only makes sense between two well-encoded samples.
            w_trn[d]   = $onehot(w_cur[d]) && $onehot(r_prev[d]) &&
                         (((r_prev[d] == c_GRN) && (w_cur[d] == c_RED)) ||
                          ((r_prev[d] == c_YEL) && (w_cur[d] == c_GRN)) ||
                          ((r_prev[d] == c_RED) && (w_cur[d] == c_YEL)));
            w_gsh[d]   = (r_prev[d] == c_GRN) && (w_cur[d] == c_YEL) && (r_dur[d] < c_MIN_G);
            w_glg[d]   = (r_prev[d] == c_GRN) && (w_cur[d] == c_GRN) && (r_dur[d] == c_MAX_G);
            w_yel[d]   = (r_prev[d] == c_YEL) &&
                         (((w_cur[d] == c_RED) && (r_dur[d] < c_MIN_Y)) ||
                          ((w_cur[d] == c_YEL) && (r_dur[d] == c_MAX_Y)));
            w_onset[d] = (r_prev[d] == c_RED) && (w_cur[d] == c_GRN);
            w_ord[d]   = w_onset[d] && !r_first_green && (2'(d) != w_succ);
        end
    end

    assign w_conf      = ($countones(w_gy) > 1) ? (w_gy & (~w_gy + 4'd1)) : 4'd0;
    assign w_vec       = {w_ord, w_yel, w_glg, w_gsh, w_trn, w_conf, w_enc, 4'd0};
    assign w_onset_num = 3'($countones(w_onset));

    // Walk codes high to low so the lowest violated code is the one left standing.
    always_comb begin
        w_any  = 1'b0;
        w_code = 3'd0;
        w_dir  = 2'd0;
        for (int c = 7; c >= 1; c--) begin
            if (|w_vec[c]) begin
                w_any  = 1'b1;
                w_code = 3'(c);
                w_dir  = f_lowest(w_vec[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                r_prev[d] <= c_RED;
                r_dur[d]  <= '0;
            end else begin
                r_prev[d] <= w_cur[d];
                if (w_cur[d] != r_prev[d]) begin
                    r_dur[d] <= CNT_W'(1);
                end else if (r_dur[d] != '1) begin
                    r_dur[d] <= r_dur[d] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first_green <= 1'b1;
            r_fault       <= 1'b0;
            r_fault_code  <= 3'd0;
            r_fault_dir   <= 2'd0;
            r_fault_cnt   <= '0;
            r_phase_cnt   <= '0;
            r_active_dir  <= 2'd0;
        end else begin
            if (w_any) begin
                if (r_fault_cnt != '1) r_fault_cnt <= r_fault_cnt + CNT_W'(1);
                if (!r_fault) begin
                    r_fault      <= 1'b1;
                    r_fault_code <= w_code;
                    r_fault_dir  <= w_dir;
                end
            end
            if (|w_onset) begin
                r_phase_cnt   <= r_phase_cnt + CNT_W'(w_onset_num);
                r_active_dir  <= f_lowest(w_onset);
                r_first_green <= 1'b0;
            end
        end
    end

    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;
    assign bus.fault_dir  = r_fault_dir;
    assign bus.fault_cnt  = r_fault_cnt;
    assign bus.phase_cnt  = r_phase_cnt;
    assign bus.active_dir = r_active_dir;
endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed bench with a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    traffic_light_monitor_if #(.CNT_W(8)) bus();

    traffic_light_monitor #(
        .MIN_GREEN(4), .MAX_GREEN(16), .MIN_YELLOW(2), .MAX_YELLOW(4), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: full sample history since reset, lights packed {W,S,E,N}.
    logic [11:0] hist[$];
    bit          m_fault;
    int          m_code, m_dir, m_fcnt, m_phase, m_active;
    bit          m_first;

    function automatic logic [2:0] light_of(input logic [11:0] smp, input int d);
        return smp[d*3 +: 3];
    endfunction

    function automatic bit is_colour(input logic [2:0] x);
        return (x == R) || (x == Y) || (x == G);
    endfunction

    task automatic model_step(input logic r, input logic [11:0] cur);
        logic [2:0] prv [4];
        logic [2:0] now [4];
        int  dur [4];
        int  lit, onsets, first_onset;
        bit  hit;
        if (r) begin
            hist.delete();
            m_fault = 0; m_code = 0; m_dir = 0; m_fcnt = 0;
            m_phase = 0; m_active = 0; m_first = 1;
            return;
        end
        lit = 0;
        for (int d = 0; d < 4; d++) begin
            now[d] = light_of(cur, d);
            prv[d] = (hist.size() == 0) ? R : light_of(hist[$], d);
            dur[d] = 0;
            for (int k = hist.size() - 1; k >= 0; k--) begin
                if (light_of(hist[k], d) != prv[d]) break;
                dur[d]++;
            end
            if (dur[d] > 255) dur[d] = 255;
            if (now[d][0] || now[d][1]) lit++;
        end
        hit = 0;
        for (int c = 1; c <= 7 && !hit; c++) begin
            for (int d = 0; d < 4 && !hit; d++) begin
                bit v;
                case (c)
                    1: v = !is_colour(now[d]);
                    2: begin
                        v = (lit > 1) && (now[d][0] || now[d][1]);
                        for (int j = 0; j < d; j++) if (now[j][0] || now[j][1]) v = 0;
                    end
                    3: v = is_colour(now[d]) && is_colour(prv[d]) &&
                           ((prv[d] == G && now[d] == R) || (prv[d] == Y && now[d] == G) ||
                            (prv[d] == R && now[d] == Y));
                    4: v = prv[d] == G && now[d] == Y && dur[d] < 4;
                    5: v = prv[d] == G && now[d] == G && dur[d] == 16;
                    6: v = prv[d] == Y && ((now[d] == R && dur[d] < 2) || (now[d] == Y && dur[d] == 4));
                    default: v = prv[d] == R && now[d] == G && !m_first && d != (m_active + 1) % 4;
                endcase
                if (v) begin
                    hit = 1;
                    if (m_fcnt < 255) m_fcnt++;
                    if (!m_fault) begin m_fault = 1; m_code = c; m_dir = d; end
                end
            end
        end
        onsets = 0;
        first_onset = -1;
        for (int d = 0; d < 4; d++) begin
            if (prv[d] == R && now[d] == G) begin
                onsets++;
                if (first_onset < 0) first_onset = d;
            end
        end
        if (onsets > 0) begin
            m_phase  = (m_phase + onsets) % 256;
            m_active = first_onset;
            m_first  = 0;
        end
        hist.push_back(cur);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One comparison process: DUT against the model on every cycle after the first sample.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc.fault",      int'(bus.fault),      int'(m_fault));
            check("cyc.fault_code", int'(bus.fault_code), m_code);
            check("cyc.fault_dir",  int'(bus.fault_dir),  m_dir);
            check("cyc.fault_cnt",  int'(bus.fault_cnt),  m_fcnt);
            check("cyc.phase_cnt",  int'(bus.phase_cnt),  m_phase);
            check("cyc.active_dir", int'(bus.active_dir), m_active);
        end
    end

    task automatic step(input logic [2:0] n, e, s, w, input logic r);
        bus.n_light = n; bus.e_light = e; bus.s_light = s; bus.w_light = w;
        rst = r;
        @(posedge clk);
        model_step(r, {w, s, e, n});
        chk_en = 1'b1;
        #1;
    endtask

    task automatic hold(input logic [2:0] n, e, s, w, input int cycles);
        for (int i = 0; i < cycles; i++) step(n, e, s, w, 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            step(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
    endtask

    // Literal expectations checked on both the DUT and the model.
    task automatic expect_out(input string tag, input int f, input int code, input int dir,
                              input int fcnt, input int phase, input int act);
        check({tag, ".fault"},      int'(bus.fault),      f);
        check({tag, ".code"},       int'(bus.fault_code), code);
        check({tag, ".dir"},        int'(bus.fault_dir),  dir);
        check({tag, ".fault_cnt"},  int'(bus.fault_cnt),  fcnt);
        check({tag, ".phase_cnt"},  int'(bus.phase_cnt),  phase);
        check({tag, ".active_dir"}, int'(bus.active_dir), act);
        check({tag, ".model_code"}, m_code, code);
        check({tag, ".model_fcnt"}, m_fcnt, fcnt);
    endtask

    initial begin
        // Reset with random lights, then all red
        do_reset();
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        hold(R, R, R, R, 5);
        expect_out("all_red", 0, 0, 0, 0, 0, 0);

        // Legal round N, E, S, W
        hold(G, R, R, R, 4); hold(Y, R, R, R, 2); hold(R, R, R, R, 1);
        expect_out("legal_n", 0, 0, 0, 0, 1, 0);
        hold(R, G, R, R, 4); hold(R, Y, R, R, 2); hold(R, R, R, R, 1);
        hold(R, R, G, R, 4); hold(R, R, Y, R, 2); hold(R, R, R, R, 1);
        hold(R, R, R, G, 4); hold(R, R, R, Y, 2); hold(R, R, R, R, 1);
        expect_out("legal_round", 0, 0, 0, 0, 4, 3);

        // Conflict
        do_reset();
        step(G, G, R, R, 1'b0);
        expect_out("conflict", 1, 2, 0, 1, 2, 0);

        // Green too short
        do_reset();
        hold(G, R, R, R, 3); step(Y, R, R, R, 1'b0);
        expect_out("green_short", 1, 4, 0, 1, 1, 0);

        // Green too long: exactly MAX_GREEN is fine, one more is not
        do_reset();
        hold(R, G, R, R, 16);
        expect_out("green_16", 0, 0, 0, 0, 1, 1);
        step(R, G, R, R, 1'b0);
        expect_out("green_17", 1, 5, 1, 1, 1, 1);
        hold(R, G, R, R, 3);
        expect_out("green_once", 1, 5, 1, 1, 1, 1);

        // Yellow too short
        do_reset();
        hold(G, R, R, R, 4); step(Y, R, R, R, 1'b0); step(R, R, R, R, 1'b0);
        expect_out("yellow_short", 1, 6, 0, 1, 1, 0);

        // Yellow too long: four cycles fine, fifth flags
        do_reset();
        hold(G, R, R, R, 4); hold(Y, R, R, R, 4);
        expect_out("yellow_4", 0, 0, 0, 0, 1, 0);
        step(Y, R, R, R, 1'b0);
        expect_out("yellow_5", 1, 6, 0, 1, 1, 0);

        // Order violation: E skipped
        do_reset();
        hold(G, R, R, R, 4); hold(Y, R, R, R, 2); hold(R, R, R, R, 1);
        step(R, R, G, R, 1'b0);
        expect_out("order", 1, 7, 2, 1, 2, 2);

        // Illegal G->R on W
        do_reset();
        step(R, R, R, G, 1'b0); step(R, R, R, R, 1'b0);
        expect_out("transition", 1, 3, 3, 1, 1, 3);

        // Priority, saturating-style counting, then reset mid-fault
        do_reset();
        step(3'b011, G, G, R, 1'b0);
        expect_out("priority", 1, 1, 0, 1, 2, 1);
        hold(3'b011, G, G, R, 5);
        expect_out("priority_cnt", 1, 1, 0, 6, 2, 1);
        step(3'b011, G, G, R, 1'b1);
        expect_out("rst_pulse", 0, 0, 0, 0, 0, 0);
        hold(R, R, R, R, 2);
        expect_out("post_rst", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 1 expected 0");
        $fatal(1);
    end
endmodule

`default_nettype wire
